val2_shift_sequencer: RTL and testbench

Multi-cycle sequencer for the EXE-stage second-operand path. It accepts one operand request at a time and performs the shift or rotate iteratively, up to STEP bit positions per clock. Supported operand forms are memory offset, rotated immediate, shift by immediate, and shift by register (Rs). It holds `busy` for the pipeline hazard unit until `valid` delivers Val2 to the ALU input.

---
 rtl/val2_shift_sequencer.sv | 74 +++++++
 tb/tb_val2_shift_sequencer.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/val2_shift_sequencer.sv
// val2_shift_sequencer: iterative Val2 shifter/rotator for the EXE second-operand path
module val2_shift_sequencer #(
  parameter int STEP = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        flush,
  input  logic        mem_en,
  input  logic        I,
  input  logic        shift_by_reg,
  input  logic [11:0] shifter,
  input  logic [31:0] register,
  input  logic [7:0]  rs_val,
  output logic [31:0] result,
  output logic        valid,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_n;
  logic [31:0] result_n, init_val, shifted;
  logic signed [31:0] sra;
  logic [1:0] typ, typ_n, init_typ;
  logic [5:0] rem, rem_n, init_amt, k;
  logic rs_big, accept;
  always_comb begin
    rs_big = |rs_val[7:5];
    init_typ = mem_en ? 2'b00 : I ? 2'b11 : shifter[6:5];
    init_val = mem_en ? {{20{shifter[11]}}, shifter} : I ? {24'b0, shifter[7:0]} : register;
    init_amt = mem_en ? 6'd0 : I ? {1'b0, shifter[11:8], 1'b0} :
               !shift_by_reg ? {1'b0, shifter[11:7]} :
               (init_typ == 2'b11 || !rs_big) ? {1'b0, rs_val[4:0]} :
               init_typ == 2'b10 ? 6'd31 : 6'd32;
    k = rem < 6'(STEP) ? rem : 6'(STEP);
    sra = $signed(result) >>> k;
    shifted = typ == 2'b00 ? result << k : typ == 2'b01 ? result >> k : typ == 2'b10 ? sra :
              (result >> k) | (result << (6'd32 - k));
    accept = state == IDLE && start && !flush;
    state_n = state;
    result_n = result;
    typ_n = typ;
    rem_n = rem;
    if (accept) begin
      state_n = init_amt == 6'd0 ? DONE : SHIFT;
      result_n = init_val;
      typ_n = init_typ;
      rem_n = init_amt;
    end else if (state != IDLE && flush) begin
      state_n = IDLE;
      rem_n = 6'd0;
    end else if (state == SHIFT) begin
      result_n = shifted;
      rem_n = rem - k;
      state_n = rem == k ? DONE : SHIFT;
    end else if (state == DONE) begin
      state_n = IDLE;
    end
  end
  assign busy = state != IDLE;
  assign valid = state == DONE && !flush;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      result <= 32'h0;
      typ <= 2'b00;
      rem <= 6'd0;
    end else begin
      state <= state_n;
      result <= result_n;
      typ <= typ_n;
      rem <= rem_n;
    end
  end
endmodule

// File: tb/tb_val2_shift_sequencer.sv
// tb_val2_shift_sequencer: randomized self-checking bench against a bit-serial reference model
module tb_val2_shift_sequencer;
  localparam int STEP = 4;
  logic clk = 1'b0;
  logic rst, start, flush, mem_en, I, shift_by_reg, busy, valid;
  logic [11:0] shifter;
  logic [31:0] register, result;
  logic [7:0] rs_val;
  int n_cmp = 0, n_bad = 0;
  val2_shift_sequencer #(.STEP(STEP)) dut (
    .clk(clk), .rst(rst), .start(start), .flush(flush), .mem_en(mem_en), .I(I),
    .shift_by_reg(shift_by_reg), .shifter(shifter), .register(register), .rs_val(rs_val),
    .result(result), .valid(valid), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask
  function automatic logic [31:0] ref_shift(input logic [31:0] v, input logic [1:0] t, input int a);
    logic signed [31:0] s;
    logic [31:0] r;
    r = v;
    s = v;
    if (t == 2'd2) begin
      for (int i = 0; i < a; i++) s = s >>> 1;
      return s;
    end
    for (int i = 0; i < a; i++) r = t == 2'd0 ? r << 1 : t == 2'd1 ? r >> 1 : {r[0], r[31:1]};
    return r;
  endfunction
  task automatic model(input logic m, input logic im, input logic sbr, input logic [11:0] sh,
                       input logic [31:0] rg, input logic [7:0] rs,
                       output logic [31:0] v, output logic [1:0] t, output int a);
    if (m) begin
      v = {{20{sh[11]}}, sh};
      t = 2'd0;
      a = 0;
    end else if (im) begin
      v = {24'b0, sh[7:0]};
      t = 2'd3;
      a = 2 * int'(sh[11:8]);
    end else begin
      v = rg;
      t = sh[6:5];
      if (!sbr) a = int'(sh[11:7]);
      else if (t == 2'd3) a = int'(rs) % 32;
      else if (int'(rs) >= 32) a = t == 2'd2 ? 31 : 32;
      else a = int'(rs);
    end
  endtask
  task automatic scramble();
    mem_en = 1'($urandom);
    I = 1'($urandom);
    shift_by_reg = 1'($urandom);
    shifter = 12'($urandom);
    register = $urandom;
    rs_val = 8'($urandom);
  endtask
  task automatic run_req(input logic m, input logic im, input logic sbr, input logic [11:0] sh,
                         input logic [31:0] rg, input logic [7:0] rs, input int fl_mode, input int st_mode);
    logic [31:0] v, fin;
    logic [1:0] t;
    int a, n, fl_at, st_at;
    model(m, im, sbr, sh, rg, rs, v, t, a);
    n = (a + STEP - 1) / STEP;
    fin = ref_shift(v, t, a);
    fl_at = fl_mode != -2 ? fl_mode : (n > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(0, n - 1)) : -1;
    st_at = st_mode != -2 ? st_mode : (n > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(0, n - 1)) : -1;
    mem_en = m;
    I = im;
    shift_by_reg = sbr;
    shifter = sh;
    register = rg;
    rs_val = rs;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    scramble();
    for (int j = 0; j <= n + 1; j++) begin
      @(negedge clk);
      start = 1'b0;
      if (fl_at >= 0 && j == fl_at + 1) begin
        flush = 1'b0;
        chk("flush_busy", 32'(busy), 32'd0);
        chk("flush_valid", 32'(valid), 32'd0);
        chk("flush_result", result, ref_shift(v, t, a < fl_at * STEP ? a : fl_at * STEP));
        return;
      end
      chk("busy", 32'(busy), 32'(j <= n));
      chk("valid", 32'(valid), 32'(j == n));
      if (j >= n) chk("result", result, fin);
      if (j == fl_at) flush = 1'b1;
      if (j == st_at) begin
        scramble();
        start = 1'b1;
      end
    end
  endtask
  initial begin
    rst = 1'b1;
    start = 1'b0;
    flush = 1'b0;
    scramble();
    repeat (2) @(negedge clk);
    chk("rst_result", result, 32'h0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    run_req(1'b1, 1'b0, 1'b0, 12'h800, 32'h0, 8'd0, -1, -1);
    chk("tp_mem", result, 32'hFFFFF800);
    run_req(1'b0, 1'b1, 1'b0, 12'h4FF, 32'h0, 8'd0, -1, -1);
    chk("tp_imm_ror", result, 32'hFF000000);
    run_req(1'b0, 1'b0, 1'b0, 12'h2C0, 32'h80000000, 8'd0, -1, -1);
    chk("tp_asr5", result, 32'hFC000000);
    run_req(1'b0, 1'b0, 1'b1, 12'h000, 32'hFFFFFFFF, 8'd40, -1, -1);
    chk("tp_lsl_clamp", result, 32'h0);
    run_req(1'b0, 1'b0, 1'b1, 12'h040, 32'hFFFFFFFF, 8'd40, -1, -1);
    chk("tp_asr_clamp", result, 32'hFFFFFFFF);
    run_req(1'b0, 1'b0, 1'b1, 12'h060, 32'h0000000F, 8'd36, -1, 0);
    chk("tp_ror_rs", result, 32'hF0000000);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("tp_no_second_valid", 32'(valid), 32'd0);
    end
    run_req(1'b1, 1'b1, 1'b0, 12'h9AB, 32'h0, 8'd0, -1, -1);
    chk("tp_mem_priority", result, 32'hFFFFF9AB);
    run_req(1'b0, 1'b0, 1'b0, 12'hA20, 32'hDEADBEEF, 8'd0, 1, -1);
    chk("tp_flush", result, 32'h0DEADBEE);
    mem_en = 1'b0;
    I = 1'b0;
    shift_by_reg = 1'b0;
    shifter = 12'hA20;
    register = 32'hDEADBEEF;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("tp_rst_result", result, 32'h0);
    chk("tp_rst_busy", 32'(busy), 32'd0);
    chk("tp_rst_valid", 32'(valid), 32'd0);
    for (int i = 0; i < 80; i++) begin
      run_req($urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0, 1'($urandom), 12'($urandom), $urandom,
              $urandom_range(0, 1) ? 8'($urandom_range(0, 63)) : 8'($urandom), -2, -2);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
